// File: rtl/hash_bridge_pkg.sv
// hash_bridge_pkg: opcodes, result flag positions and field offsets shared by the hash stream bridge.
package hash_bridge_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_DELETE, OP_RSVD} op_e;
  localparam int FLAGS_W = 4;
  localparam int FLAG_KEY_PRESENT = 3;
  localparam int FLAG_NO_ELEMENT = 2;
  localparam int FLAG_NO_SPACE = 1;
  localparam int FLAG_NO_DELETE = 0;
  function automatic int key_msb(input int out_w);
    return out_w - FLAGS_W - 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; unregistered read data from the head slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic push_ok, pop_ok;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign push_ok = push & !full;
  assign pop_ok = pop & !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push_ok) mem[wr] <= din;
      wr <= wr + AW'(push_ok);
      rd <= rd + AW'(pop_ok);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/axis_hash_bridge.sv
// axis_hash_bridge: AXI-Stream front end for hash_table; credit-gated request issue,
// in-order result buffering, local reserved-op results and a saturating error counter.
module axis_hash_bridge
  import hash_bridge_pkg::*;
#(
  parameter int KEY_WIDTH  = 5,
  parameter int DATA_WIDTH = 25,
  parameter int OUT_WIDTH  = 64,
  parameter int ECHO_KEY   = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0]         data_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  logic                                      last_i,
  input  logic [(2+KEY_WIDTH+DATA_WIDTH+7)/8-1:0]   keep_i,
  output logic [OUT_WIDTH-1:0]                      data_o,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic                                      last_o,
  output logic [OUT_WIDTH/8-1:0]                    keep_o,
  output logic                                      req_valid_o,
  input  logic                                      req_ready_i,
  output logic [1:0]                                req_op_o,
  output logic [KEY_WIDTH-1:0]                      req_key_o,
  output logic [DATA_WIDTH-1:0]                     req_data_o,
  input  logic                                      rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                     rsp_data_i,
  input  logic [3:0]                                rsp_flags_i,
  output logic [15:0]                               err_count_o
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int KMSB = key_msb(OUT_WIDTH);
  if (OUT_WIDTH % 8 != 0 || OUT_WIDTH < FLAGS_W + DATA_WIDTH + ECHO_KEY * KEY_WIDTH) begin : g_width_check
    $error("axis_hash_bridge: OUT_WIDTH must be a multiple of 8 and hold flags, key and data");
  end
  logic [1:0] op;
  logic [KEY_WIDTH-1:0] key, tag_key;
  logic [DATA_WIDTH-1:0] data;
  logic legal, credit_ok, accept, rsvd_acc, rsp_ok, pop;
  logic tag_last, tag_full, tag_empty, res_full, res_empty, res_last, res_dout_last;
  logic [CW-1:0] outstanding, res_count;
  logic [CW:0] used;
  logic [OUT_WIDTH-1:0] res_word, res_dout;
  logic unused_sig;
  assign {op, key, data} = data_i;
  assign legal = op != OP_RSVD;
  assign used = {1'b0, outstanding} + {1'b0, res_count};
  assign credit_ok = used < (CW+1)'(RSP_DEPTH);
  assign req_valid_o = !reset & valid_i & legal & credit_ok;
  // reserved op waits for the core to drain so its local result keeps response order
  assign ready_o = !reset & (legal ? req_ready_i & credit_ok : outstanding == '0 & !res_full);
  assign {req_op_o, req_key_o, req_data_o} = data_i;
  assign accept = valid_i & ready_o & legal;
  assign rsvd_acc = valid_i & ready_o & !legal;
  assign rsp_ok = rsp_valid_i & !tag_empty;
  assign pop = valid_o & ready_i;
  assign res_last = rsvd_acc ? last_i : tag_last;
  assign valid_o = !res_empty;
  assign data_o = res_empty ? '0 : res_dout;
  assign last_o = !res_empty & res_dout_last;
  assign keep_o = '1;
  assign unused_sig = ^{keep_i, tag_full};
  always_comb begin
    res_word = '0;
    res_word[OUT_WIDTH-1 -: FLAGS_W] = rsvd_acc ? 4'hF : rsp_flags_i;
    if (ECHO_KEY != 0) res_word[KMSB -: KEY_WIDTH] = rsvd_acc ? key : tag_key;
    res_word[DATA_WIDTH-1:0] = rsvd_acc ? '0 : rsp_data_i;
  end
  sync_fifo #(.WIDTH(KEY_WIDTH+1), .DEPTH(RSP_DEPTH)) u_tag (
    .clk(clk), .reset(reset), .push(accept), .pop(rsp_ok), .din({last_i, key}),
    .dout({tag_last, tag_key}), .full(tag_full), .empty(tag_empty), .count(outstanding)
  );
  sync_fifo #(.WIDTH(OUT_WIDTH+1), .DEPTH(RSP_DEPTH)) u_res (
    .clk(clk), .reset(reset), .push(rsp_ok | rsvd_acc), .pop(pop), .din({res_last, res_word}),
    .dout({res_dout_last, res_dout}), .full(res_full), .empty(res_empty), .count(res_count)
  );
  always_ff @(posedge clk) begin
    if (reset) err_count_o <= '0;
    else if (pop && |res_dout[OUT_WIDTH-1 -: FLAGS_W] && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
  end
endmodule

// File: tb/tb_axis_hash_bridge.sv
// tb_axis_hash_bridge: directed bench with a behavioural core and result-order model.
module tb_axis_hash_bridge;
  localparam int KW = 5, DW = 25, OW = 64, IW = 2 + KW + DW;
  logic clk = 0, reset = 1;
  logic [IW-1:0] data_i = '0;
  logic valid_i = 0, last_i = 0, ready_i = 0, req_ready_i = 1;
  logic [(IW+7)/8-1:0] keep_i = '1;
  logic ready_o, valid_o, last_o, req_valid_o;
  logic [OW-1:0] data_o;
  logic [OW/8-1:0] keep_o;
  logic [1:0] req_op_o;
  logic [KW-1:0] req_key_o;
  logic [DW-1:0] req_data_o;
  logic rsp_valid_i = 0;
  logic [DW-1:0] rsp_data_i = '0;
  logic [3:0] rsp_flags_i = '0;
  logic [15:0] err_count_o;

  axis_hash_bridge dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .last_i(last_i), .keep_i(keep_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .keep_o(keep_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_op_o(req_op_o), .req_key_o(req_key_o), .req_data_o(req_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_flags_i(rsp_flags_i),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [OW-1:0] w; logic l; } exp_t;
  typedef struct { int due; logic [3:0] f; logic [DW-1:0] d; } core_t;
  exp_t exp_q[$];
  core_t core_q[$];
  logic [OW-1:0] pops[$];
  int errors = 0, checks = 0, cyc = 0, req_cnt = 0, acc_cyc = 0, pop_cyc = 0;
  logic [15:0] err_m = 0;
  logic [3:0] p_flags = 0;
  logic [DW-1:0] p_data = 0;
  int p_dly = 1;
  logic hold = 0, hold_l = 0, last_l = 0;
  logic [OW-1:0] hold_w = 0, last_w = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [OW-1:0] pack(input logic [3:0] f, input logic [KW-1:0] k, input logic [DW-1:0] d);
    logic [OW-1:0] r;
    r = {f, {(OW-4){1'b0}}};
    r = r | ({{(OW-KW){1'b0}}, k} << (OW - 4 - KW));
    r = r | {{(OW-DW){1'b0}}, d};
    return r;
  endfunction

  // result model and per-cycle compare
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      core_q.delete();
      err_m = 0;
      hold = 0;
    end else begin
      chk("err_count", 64'(err_count_o), 64'(err_m));
      if (hold) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_data", data_o, hold_w);
        chk("hold_last", 64'(last_o), 64'(hold_l));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_result", data_o, 64'hX);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_data", data_o, e.w);
          chk("result_last", 64'(last_o), 64'(e.l));
          if (e.w[OW-1 -: 4] != 0 && err_m != 16'hFFFF) err_m++;
          last_w = data_o;
          last_l = last_o;
          pops.push_back(data_o);
          pop_cyc = cyc;
        end
      end
      hold = valid_o && !ready_i;
      hold_w = data_o;
      hold_l = last_o;
      chk("req_handshake", 64'(req_valid_o && req_ready_i), 64'(valid_i && ready_o && data_i[IW-1 -: 2] != 2'b11));
      if (req_valid_o) chk("req_fields", {req_op_o, req_key_o, req_data_o}, 64'(data_i));
      if (req_valid_o && req_ready_i) req_cnt++;
      if (valid_i && ready_o) begin
        acc_cyc = cyc;
        if (data_i[IW-1 -: 2] == 2'b11) exp_q.push_back({pack(4'hF, data_i[DW +: KW], '0), last_i});
        else begin
          exp_q.push_back({pack(p_flags, data_i[DW +: KW], p_data), last_i});
          core_q.push_back('{cyc + p_dly, p_flags, p_data});
        end
      end
    end
  end

  // core model: answers accepted requests in order after their planned delay
  initial forever begin
    @(posedge clk);
    #1;
    rsp_valid_i = 0;
    if (core_q.size() > 0 && core_q[0].due <= cyc + 1) begin
      core_t c;
      c = core_q.pop_front();
      rsp_valid_i = 1;
      rsp_flags_i = c.f;
      rsp_data_i = c.d;
    end
  end

  task automatic set_req(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d, input logic l,
                         input logic [3:0] f, input logic [DW-1:0] rd, input int dly);
    data_i = {op, k, d};
    last_i = l;
    p_flags = f;
    p_data = rd;
    p_dly = dly;
    valid_i = 1;
  endtask

  task automatic wait_acc(input int lim, output int waited);
    bit got;
    got = 0;
    waited = 0;
    while (!got && waited < lim) begin
      @(negedge clk);
      got = ready_o && !reset;
      @(posedge clk);
      #1;
      if (!got) waited++;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    valid_i = 0;
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base;
    repeat (2) @(posedge clk);
    #1;
    set_req(2'b01, 5'd1, 25'd1, 1, 4'h0, 25'd1, 1);
    @(negedge clk);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_last_o", 64'(last_o), 64'd0);
    chk("rst_data_o", data_o, 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_err", 64'(err_count_o), 64'd0);
    chk("keep_o", 64'(keep_o), 64'hFF);
    @(posedge clk);
    #1;
    reset = 0;
    valid_i = 0;
    ready_i = 1;
    // write key 5, core answers flags 0 after 3 cycles
    set_req(2'b01, 5'd5, 25'h123, 1, 4'h0, 25'h123, 3);
    wait_acc(20, w);
    chk("t1_accept_wait", 64'(w), 64'd0);
    wait_drain(50);
    chk("t1_word", last_w, 64'h0280_0000_0000_0123);
    chk("t1_last", 64'(last_l), 64'd1);
    chk("t1_latency", 64'(pop_cyc - acc_cyc), 64'd4);
    chk("t1_err", 64'(err_count_o), 64'd0);
    // read of absent key
    set_req(2'b00, 5'd7, 25'd0, 0, 4'b0100, 25'd0, 2);
    wait_acc(20, w);
    wait_drain(50);
    chk("t2_word", last_w, 64'h4380_0000_0000_0000);
    chk("t2_last", 64'(last_l), 64'd0);
    chk("t2_err", 64'(err_count_o), 64'd1);
    // credit exhaustion with the output stalled
    ready_i = 0;
    base = req_cnt;
    for (int i = 0; i < 4; i++) begin
      set_req(2'b01, KW'(i), DW'(i), i == 3, 4'h0, DW'(16 + i), 1);
      wait_acc(20, w);
    end
    set_req(2'b01, 5'd4, 25'd4, 0, 4'h0, 25'h14, 1);
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t3_ready_low", 64'(ready_o), 64'd0);
    chk("t3_core_reqs4", 64'(req_cnt - base), 64'd4);
    chk("t3_buffered", 64'(valid_o), 64'd1);
    @(posedge clk);
    #1;
    ready_i = 1;
    @(negedge clk);
    chk("t3_ready_in_pop_cycle", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    ready_i = 0;
    @(negedge clk);
    chk("t3_ready_after_pop", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_core_reqs5", 64'(req_cnt - base), 64'd5);
    set_req(2'b01, 5'd5, 25'd5, 1, 4'h0, 25'h15, 1);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t3_ready_low_again", 64'(ready_o), 64'd0);
    chk("t3_core_reqs_still5", 64'(req_cnt - base), 64'd5);
    @(posedge clk);
    #1;
    ready_i = 1;
    wait_acc(20, w);
    wait_drain(50);
    chk("t3_core_reqs6", 64'(req_cnt - base), 64'd6);
    // reserved op behind two outstanding reads
    set_req(2'b00, 5'd9, 25'd0, 0, 4'h0, 25'h21, 5);
    wait_acc(20, w);
    set_req(2'b00, 5'd10, 25'd0, 1, 4'h0, 25'h22, 5);
    wait_acc(20, w);
    set_req(2'b11, 5'd0, 25'd0, 1, 4'h0, 25'd0, 0);
    @(negedge clk);
    chk("t4_rsvd_stalled", 64'(ready_o), 64'd0);
    wait_acc(30, w);
    chk("t4_rsvd_wait", 64'(w), 64'd4);
    wait_drain(50);
    chk("t4_first", pops[pops.size()-3], 64'h0480_0000_0000_0021);
    chk("t4_second", pops[pops.size()-2], 64'h0500_0000_0000_0022);
    chk("t4_third_rsvd", pops[pops.size()-1], 64'hF000_0000_0000_0000);
    chk("t4_rsvd_last", 64'(last_l), 64'd1);
    chk("t4_rsvd_latency", 64'(pop_cyc - acc_cyc), 64'd1);
    chk("t4_err", 64'(err_count_o), 64'd2);
    // reset with two outstanding and one buffered
    ready_i = 0;
    set_req(2'b00, 5'd1, 25'd0, 0, 4'h0, 25'h31, 1);
    wait_acc(20, w);
    set_req(2'b00, 5'd2, 25'd0, 0, 4'h0, 25'h32, 20);
    wait_acc(20, w);
    set_req(2'b00, 5'd3, 25'd0, 0, 4'h0, 25'h33, 20);
    wait_acc(20, w);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t5_buffered", 64'(valid_o), 64'd1);
    @(posedge clk);
    #1;
    reset = 1;
    set_req(2'b01, 5'd6, 25'h66, 1, 4'h0, 25'h66, 1);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("t5_valid_o", 64'(valid_o), 64'd0);
    chk("t5_data_o", data_o, 64'd0);
    chk("t5_err", 64'(err_count_o), 64'd0);
    chk("t5_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 0;
    ready_i = 1;
    wait_drain(50);
    chk("t5_word", last_w, 64'h0300_0000_0000_0066);
    // error counter saturation
    for (int i = 0; i < 70000; i++) begin
      set_req(2'b01, KW'(i), DW'(i), 1'(i), 4'b0001, DW'(i), 1);
      wait_acc(20, w);
    end
    wait_drain(100);
    chk("t6_err_saturated", 64'(err_count_o), 64'hFFFF);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_err_held", 64'(err_count_o), 64'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
